// File: rtl/cic_pkg.sv
// Shared CIC constants, width helper and accumulator type used by the
// integrator/decimator and by the downstream comb section.
package cic_pkg;

  localparam int CIC_N  = 3;
  localparam int CIC_R  = 256;
  localparam int CIC_IW = 13;

  // Bit growth of an N-stage CIC decimating by r: iw + n*log2(r).
  function automatic int cic_ow(input int iw, input int n, input int r);
    return iw + n * $clog2(r);
  endfunction

  typedef logic signed [36:0] cic_acc_t;

endpackage

// File: rtl/cic_integrator.sv
// Single wrap-around integrator stage: q accumulates d on every enabled clock.
module cic_integrator #(
  parameter int W = 37
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] q
);

  logic signed [W-1:0] acc_reg;

  // Overflow wraps silently; the comb differentiators cancel it.
  always_ff @(posedge clk) begin
    if (rst)
      acc_reg <= '0;
    else if (en)
      acc_reg <= acc_reg + d;
  end

  assign q = acc_reg;

endmodule

// File: rtl/cic_integ_decim.sv
// CIC integrator cascade followed by decimate-by-R; emits one ND strobe
// with the retained integrator value every R enabled input samples.
module cic_integ_decim
  import cic_pkg::*;
#(
  parameter  int IW = CIC_IW,
  parameter  int R  = CIC_R,
  parameter  int N  = CIC_N,
  localparam int OW = cic_ow(IW, N, R)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 En,
  input  logic signed [IW-1:0] Xin,
  output logic signed [OW-1:0] Yout,
  output logic                 ND
);

  localparam int CW = $clog2(R);

  if (N != 3) begin : g_bad_n
    $error("cic_integ_decim: N must be 3");
  end
  if (R < 2 || (R & (R - 1)) != 0) begin : g_bad_r
    $error("cic_integ_decim: R must be a power of two >= 2");
  end

  logic signed [OW-1:0] x_reg;
  logic        [CW-1:0] cnt_reg;
  logic signed [OW-1:0] yout_reg;
  logic                 nd_reg;
  logic signed [OW-1:0] stage_q [0:N];

  assign stage_q[0] = x_reg;

  // Each stage integrates the pre-edge output of the one before it.
  for (genvar gi = 0; gi < N; gi++) begin : g_integ
    cic_integrator #(.W(OW)) u_integ (
      .clk (clk),
      .rst (rst),
      .en  (En),
      .d   (stage_q[gi]),
      .q   (stage_q[gi+1])
    );
  end

  // cnt wraps from R-1 to 0 by itself because R is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg    <= '0;
      cnt_reg  <= '0;
      yout_reg <= '0;
      nd_reg   <= 1'b0;
    end else begin
      nd_reg <= 1'b0;
      if (En) begin
        x_reg   <= {{(OW-IW){Xin[IW-1]}}, Xin};
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CW'(R - 1)) begin
          yout_reg <= stage_q[N];
          nd_reg   <= 1'b1;
        end
      end
    end
  end

  assign Yout = yout_reg;
  assign ND   = nd_reg;

endmodule

// File: tb/tb_cic_integ_decim.sv
// Randomized bench for cic_integ_decim against a closed-form convolution model.
module tb_cic_integ_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, rst4, en4;
  logic signed [12:0] xin, xin4;
  logic signed [36:0] yout;
  logic               nd;
  logic signed [18:0] yout4;
  logic               nd4;

  cic_integ_decim dut (
    .clk (clk), .rst (rst), .En (en), .Xin (xin), .Yout (yout), .ND (nd)
  );

  cic_integ_decim #(.R(4)) dut4 (
    .clk (clk), .rst (rst4), .En (en4), .Xin (xin4), .Yout (yout4), .ND (nd4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model: every accepted sample since reset, the enabled-sample count, and
  // the expected outputs. Yout at the m-th enabled sample is
  // sum_k x_k * C(m-2-k, 2), reduced mod 2^OW.
  longint      xs[$];
  int          m;
  int          r_cur;
  int          ow_cur;
  int          sel;
  logic [63:0] exp_y;
  logic        exp_nd;
  logic [63:0] strobes[$];

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] model_y(input int mm);
    longint acc = 0;
    for (int k = 1; k <= mm - 2; k++) begin
      longint n = longint'(mm - 2 - k);
      acc += xs[k-1] * ((n * (n - 1)) / 2);
    end
    return 64'(acc) & msk(ow_cur);
  endfunction

  task automatic tick(input logic r, input logic e, input int x);
    logic [63:0] oy;
    logic        ond;
    if (sel == 0) begin
      rst = r; en = e; xin = x[12:0];
      rst4 = 1'b0; en4 = 1'b0;
    end else begin
      rst4 = r; en4 = e; xin4 = x[12:0];
      rst = 1'b0; en = 1'b0;
    end
    @(posedge clk);
    #1;
    if (r) begin
      xs.delete();
      m      = 0;
      exp_y  = '0;
      exp_nd = 1'b0;
    end else begin
      exp_nd = 1'b0;
      if (e) begin
        xs.push_back(longint'(x));
        m++;
        if (m % r_cur == 0) begin
          exp_nd = 1'b1;
          exp_y  = model_y(m);
        end
      end
    end
    oy  = (sel == 0) ? {27'd0, yout} : {45'd0, yout4};
    ond = (sel == 0) ? nd : nd4;
    chk("nd", {63'd0, ond}, {63'd0, exp_nd});
    chk("yout", oy & msk(ow_cur), exp_y);
    if (ond === 1'b1) strobes.push_back(oy & msk(ow_cur));
  endtask

  logic [63:0] dc_vals[$];
  logic [63:0] d3;
  longint      want;

  initial begin
    sel = 0; r_cur = 256; ow_cur = 37;
    rst = 1'b1; en = 1'b0; xin = '0;
    rst4 = 1'b1; en4 = 1'b0; xin4 = '0;
    xs.delete(); m = 0; exp_y = '0; exp_nd = 1'b0;

    // Reset held with active En and nonzero input
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 100);

    // DC step, En continuous
    strobes.delete();
    for (int i = 0; i < 256; i++) tick(1'b0, 1'b1, 1);
    chk("dc_first_nd", {63'd0, nd}, 64'd1);
    chk("dc_first_y", {27'd0, yout}, 64'd2699004);
    for (int i = 0; i < 3 * 256; i++) tick(1'b0, 1'b1, 1);
    dc_vals = strobes;
    chk("dc_count", 64'(strobes.size()), 64'd4);

    // Sparse En: same sample sequence, En every other cycle
    tick(1'b1, 1'b0, 0);
    strobes.delete();
    for (int i = 0; i < 4 * 256; i++) begin
      tick(1'b0, 1'b1, 1);
      tick(1'b0, 1'b0, int'($urandom_range(0, 8191)) - 4096);
    end
    chk("sparse_count", 64'(strobes.size()), 64'd4);
    for (int i = 0; i < 4 && i < strobes.size() && i < dc_vals.size(); i++)
      chk("sparse_vs_dc", strobes[i], dc_vals[i]);

    // Wrap: full-scale negative input for 64 frames, then a comb check
    tick(1'b1, 1'b0, 0);
    strobes.delete();
    for (int i = 0; i < 64 * 256; i++) tick(1'b0, 1'b1, -4096);
    chk("wrap_count", 64'(strobes.size()), 64'd64);
    if (strobes.size() >= 4) begin
      d3 = (strobes[63] - 64'd3 * strobes[62] + 64'd3 * strobes[61] - strobes[60]) & msk(37);
      want = longint'(-4096) * (longint'(1) << 24);
      chk("wrap_comb", d3, 64'(want) & msk(37));
    end

    // Random samples with random En gaps
    tick(1'b1, 1'b0, 0);
    while (m < 8 * 256)
      tick(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 8191)) - 4096);

    // Mid-frame reset at cnt=100 after three frames
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 3 * 256 + 100; i++) tick(1'b0, 1'b1, 7);
    tick(1'b1, 1'b1, 7);
    chk("midrst_y", {27'd0, yout}, 64'd0);
    chk("midrst_nd", {63'd0, nd}, 64'd0);
    strobes.delete();
    for (int i = 0; i < 256; i++) tick(1'b0, 1'b1, 7);
    chk("midrst_first_nd", {63'd0, nd}, 64'd1);
    chk("midrst_first_y", {27'd0, yout}, 64'd2699004 * 64'd7);
    chk("midrst_count", 64'(strobes.size()), 64'd1);

    // Small ratio instance, R=4
    sel = 1; r_cur = 4; ow_cur = 19;
    tick(1'b1, 1'b0, 0);
    strobes.delete();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1);
    chk("r4_count", 64'(strobes.size()), 64'd3);
    if (strobes.size() >= 2) begin
      chk("r4_first", strobes[0], 64'd0);
      chk("r4_second", strobes[1], 64'd20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
